// File: rtl/updown_counter_n.sv
// updown_counter_n: up/down counter over 0..max_val with load, terminal count and sticky wrap flag.
// Defining COUNTER_SAT_EN adds a sat input; when sat=1 the counter saturates instead of wrapping.
module updown_counter_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic             oe,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             ovf
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             sat_on;
    logic             at_top, at_bot, above;

`ifdef COUNTER_SAT_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif

    assign at_top = cnt_q >= max_val;
    assign at_bot = cnt_q == '0;
    assign above  = cnt_q > max_val;

    // Next count and wrap flag; load beats enable, and a count above a lowered limit is pulled back in range.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (load) begin
            cnt_d = (d > max_val) ? max_val : d;
            ovf_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    cnt_d = sat_on ? max_val : '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else if (above) begin
                cnt_d = max_val;
            end else if (at_bot) begin
                cnt_d = sat_on ? '0 : max_val;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign tc  = en & ((up & at_top) | (~up & at_bot));
    assign y   = oe ? cnt_q : '0;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed scoreboard bench for updown_counter_n (WIDTH=8).
module tb_updown_counter_n;
    logic       clk = 1'b0;
    logic       reset_n, en, load, up, oe;
    logic [7:0] d, max_val, y;
    logic       tc, ovf;
`ifdef COUNTER_SAT_EN
    logic       sat = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] qy[$];
    logic       qt[$];
    logic       qo[$];
    string      qn[$];

    updown_counter_n #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .up(up), .oe(oe),
`ifdef COUNTER_SAT_EN
        .sat(sat),
`endif
        .d(d), .max_val(max_val), .y(y), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid at each falling edge; compare against the oldest queued expectation.
    always @(negedge clk) begin
        if (qy.size() != 0) begin
            logic [7:0] ey;
            logic       et, eo;
            string      nm;
            ey = qy.pop_front();
            et = qt.pop_front();
            eo = qo.pop_front();
            nm = qn.pop_front();
            checks++;
            if (y !== ey || tc !== et || ovf !== eo) begin
                errors++;
                $display("FAIL %s: got y=%h tc=%b ovf=%b, want y=%h tc=%b ovf=%b", nm, y, tc, ovf, ey, et, eo);
            end
        end
    end

    function automatic void expect_now(input logic [7:0] ey, input logic et, eo, input string nm);
        qy.push_back(ey);
        qt.push_back(et);
        qo.push_back(eo);
        qn.push_back(nm);
    endfunction

    // One cycle: drive inputs for the coming edge; expect the current state (y, ovf) and tc under these inputs.
    task automatic cyc(input logic ld, e, u, o, input logic [7:0] dv, mv, ey, input logic et, eo, input string nm);
        @(posedge clk);
        #2;
        load = ld; en = e; up = u; oe = o; d = dv; max_val = mv;
        expect_now(ey, et, eo, nm);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; oe = 1'b1; d = 8'h00; max_val = 8'h09;
        @(posedge clk);
        #2 reset_n = 1'b1;
        // Up wrap at max_val=9 from a load of 7
        cyc(1, 0, 1, 1, 8'h07, 8'h09, 8'h00, 0, 0, "reset_state");
        cyc(0, 1, 1, 1, 8'h00, 8'h09, 8'h07, 0, 0, "load7");
        cyc(0, 1, 1, 1, 8'h00, 8'h09, 8'h08, 0, 0, "up8");
        cyc(0, 1, 1, 1, 8'h00, 8'h09, 8'h09, 1, 0, "up9_tc");
        cyc(0, 1, 1, 1, 8'h00, 8'h09, 8'h00, 0, 1, "up_wrap0");
        cyc(0, 0, 1, 1, 8'h00, 8'h09, 8'h01, 0, 1, "up1_hold");
        // Load priority over en, and oe gating
        cyc(1, 1, 1, 1, 8'h55, 8'hFF, 8'h01, 0, 1, "pre_load55");
        cyc(0, 1, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 0, "oe_off_a");
        cyc(0, 1, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 0, "oe_off_b");
        cyc(0, 0, 1, 1, 8'h00, 8'hFF, 8'h57, 0, 0, "oe_on_57");
        // Runtime limit lowered below the count
        cyc(1, 0, 1, 1, 8'h30, 8'hFF, 8'h57, 0, 0, "hold57");
        cyc(0, 1, 1, 1, 8'h00, 8'h10, 8'h30, 1, 0, "above_up_tc");
        cyc(1, 0, 1, 1, 8'h30, 8'hFF, 8'h00, 0, 1, "above_up_wrap");
        cyc(0, 1, 0, 1, 8'h00, 8'h10, 8'h30, 0, 0, "above_dn");
        cyc(0, 0, 0, 1, 8'h00, 8'h10, 8'h10, 0, 0, "above_dn_clamp");
        cyc(1, 1, 1, 1, 8'h05, 8'h10, 8'h10, 1, 0, "load_vs_wrap_tc");
        // Clamped load then down through zero
        cyc(1, 0, 0, 1, 8'hFF, 8'h20, 8'h05, 0, 0, "load_wins");
        cyc(0, 1, 0, 1, 8'h00, 8'h20, 8'h20, 0, 0, "clamp_load");
        for (int i = 1; i < 32; i++) cyc(0, 1, 0, 1, 8'h00, 8'h20, 8'(32 - i), 0, 0, "down_run");
        cyc(0, 1, 0, 1, 8'h00, 8'h20, 8'h00, 1, 0, "down_zero_tc");
        cyc(0, 0, 0, 1, 8'h00, 8'h20, 8'h20, 0, 1, "down_wrap");
        // max_val = 0
        cyc(1, 0, 0, 1, 8'h03, 8'h00, 8'h20, 0, 1, "pre_max0");
        cyc(0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, "max0_dn");
        cyc(0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 1, 1, "max0_up");
        cyc(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 1, "max0_hold");
        // Down wrap to 0x37, then asynchronous reset mid-count
        cyc(0, 1, 0, 1, 8'h00, 8'h37, 8'h00, 1, 1, "dn_to_37");
        cyc(0, 0, 0, 1, 8'h00, 8'h37, 8'h37, 0, 1, "at37");
        @(posedge clk);
        #2;
        en = 1'b1; up = 1'b0; reset_n = 1'b0;
        expect_now(8'h00, 1, 0, "async_reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1; up = 1'b1;
        expect_now(8'h00, 0, 0, "reset_release");
        cyc(0, 0, 1, 1, 8'h00, 8'h37, 8'h01, 0, 0, "first_edge");
`ifdef COUNTER_SAT_EN
        sat = 1'b1;
        cyc(1, 0, 1, 1, 8'hFE, 8'hFF, 8'h01, 0, 0, "sat_pre");
        cyc(0, 1, 1, 1, 8'h00, 8'hFF, 8'hFE, 0, 0, "sat_fe");
        cyc(0, 1, 1, 1, 8'h00, 8'hFF, 8'hFF, 1, 0, "sat_ff_a");
        cyc(0, 1, 1, 1, 8'h00, 8'hFF, 8'hFF, 1, 1, "sat_ff_b");
        cyc(1, 0, 1, 1, 8'h00, 8'hFF, 8'hFF, 0, 1, "sat_ff_c");
        cyc(0, 1, 0, 1, 8'h00, 8'hFF, 8'h00, 1, 0, "sat_zero");
        cyc(0, 0, 0, 1, 8'h00, 8'hFF, 8'h00, 0, 1, "sat_zero_hold");
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (qy.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", qy.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter, load and limit width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable.
REQ-005 The block SHALL have port load, input, 1 bit: synchronous parallel load, which has priority over en.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = up and 0 = down.
REQ-007 The block SHALL have port oe, input, 1 bit: output enable for y.
REQ-008 The block SHALL have port d, input, WIDTH bits: the parallel load value.
REQ-009 The block SHALL have port max_val, input, WIDTH bits: the terminal value, so that the count range is 0..max_val.
REQ-010 The block SHALL have port y, output, WIDTH bits: the count when oe=1, otherwise all zeros.
REQ-011 The block SHALL have port tc, output, 1 bit: combinational terminal-count (ripple-carry lookahead) flag.
REQ-012 The block SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-013 The count register cnt SHALL update only on the rising edge of clk; when load=0 and en=0 it SHALL hold.
REQ-014 When load=1, cnt SHALL become min(d, max_val) and ovf SHALL clear, regardless of en and up.
REQ-015 When load=0, en=1, up=1 and cnt<max_val, cnt SHALL increment by 1.
REQ-016 When load=0, en=1, up=1 and cnt>=max_val, cnt SHALL wrap to 0 and ovf SHALL set; this includes cnt above a max_val that was lowered at runtime.
REQ-017 When load=0, en=1, up=0 and 0<cnt<=max_val, cnt SHALL decrement by 1.
REQ-018 When load=0, en=1, up=0 and cnt==0, cnt SHALL wrap to max_val and ovf SHALL set.
REQ-019 When load=0, en=1, up=0 and cnt>max_val, cnt SHALL become max_val with ovf unchanged.
REQ-020 max_val=0 SHALL be legal: an enabled count holds cnt at 0, sets ovf on every enabled edge, and keeps tc=1 while en=1.
REQ-021 tc SHALL equal en & ((up & cnt>=max_val) | (~up & cnt==0)), with no dependence on load or oe.
REQ-022 ovf SHALL stay set until a load or a reset; a wrap and a load in the same cycle SHALL clear ovf, because load wins.
REQ-023 y SHALL be a registered count gated combinationally by oe; oe SHALL never affect cnt, tc or ovf.
REQ-024 All additions and subtractions SHALL be WIDTH bits wide, with no implicit width extension into cnt.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force cnt=0 and ovf=0, which gives y=0 and ovf=0, without waiting for clk.
REQ-026 While reset_n=0, tc SHALL follow REQ-021 with cnt=0, so tc=en&~up, or en&up when max_val=0.
REQ-027 Reset asserted in the middle of a count or load SHALL abort it; the first rising edge after reset_n returns to 1 SHALL apply normal REQ-013..REQ-019 behaviour.

Configuration
REQ-028 Macro COUNTER_SAT_EN SHALL select between saturating and wrap-only behaviour.
REQ-029 With COUNTER_SAT_EN defined, the block SHALL add input port sat (1 bit).
REQ-030 With COUNTER_SAT_EN defined and sat=1, the REQ-016 case SHALL hold cnt at max_val, or clamp cnt to max_val if cnt>max_val, and the REQ-018 case SHALL hold cnt at 0.
REQ-031 With COUNTER_SAT_EN defined and sat=1, ovf SHALL be set whenever a wrap would have occurred.
REQ-032 With COUNTER_SAT_EN defined, tc SHALL be unchanged by sat.
REQ-033 Without COUNTER_SAT_EN, the sat port SHALL be absent and the block SHALL always wrap.

Verification (WIDTH=8)
REQ-034 Reset: assert reset_n=0 mid-count at cnt=0x37 -> y=0x00 and ovf=0 before the next clk edge.
REQ-035 Up wrap: max_val=9, load d=7, then en=1, up=1 for 4 edges -> y sequence 8, 9, 0, 1; tc=1 only while y=9; ovf=1 from the wrap edge onward.
REQ-036 Down wrap with clamped load: max_val=0x20, load d=0xFF -> y=0x20; down for 0x21 edges -> y=0x00 then 0x20; ovf=1.
REQ-037 Priority and oe: load=1, en=1, d=0x55 -> y=0x55 and ovf cleared; oe=0 -> y=0x00 while counting continues; oe=1 -> shows the advanced count.
REQ-038 Runtime limit change: cnt=0x30, change max_val to 0x10 -> up edge gives 0x00 with ovf=1; down edge from 0x30 gives 0x10 with ovf unchanged.
REQ-039 Saturation (COUNTER_SAT_EN, sat=1): max_val=0xFF, cnt=0xFE, 3 up edges -> y sequence 0xFF, 0xFF, 0xFF; ovf=1.
